// File: rtl/dht11_pkg.sv
// Shared DHT11 definitions: FSM state encoding, default bus timing, frame layout
// and the checksum used by both the responder and decoder-side validity checks.
package dht11_pkg;

  localparam int unsigned DEF_CLK_FREQ_HZ    = 50_000_000;
  localparam int unsigned DEF_START_MIN_US   = 18_000;
  localparam int unsigned DEF_REPLY_DELAY_US = 30;
  localparam int unsigned DEF_ACK_US         = 80;
  localparam int unsigned DEF_BIT_LOW_US     = 50;
  localparam int unsigned DEF_BIT0_HIGH_US   = 27;
  localparam int unsigned DEF_BIT1_HIGH_US   = 70;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_HOST_LOW = 3'd1;
  localparam logic [2:0] S_DELAY    = 3'd2;
  localparam logic [2:0] S_ACK_LOW  = 3'd3;
  localparam logic [2:0] S_ACK_HIGH = 3'd4;
  localparam logic [2:0] S_BIT_LOW  = 3'd5;
  localparam logic [2:0] S_BIT_HIGH = 3'd6;
  localparam logic [2:0] S_END_LOW  = 3'd7;

  // Wire order of the 40-bit frame, MSB sent first.
  typedef struct packed {
    logic [7:0] hum_int;
    logic [7:0] hum_float;
    logic [7:0] temp_int;
    logic [7:0] temp_float;
    logic [7:0] checksum;
  } dht11_frame_t;

  function automatic logic [7:0] dht11_checksum(input logic [7:0] hi, input logic [7:0] hf,
                                                input logic [7:0] ti, input logic [7:0] tf);
    return hi + hf + ti + tf;
  endfunction

  function automatic logic dht11_frame_valid(input dht11_frame_t f);
    return dht11_checksum(f.hum_int, f.hum_float, f.temp_int, f.temp_float) == f.checksum;
  endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Free-running prescaler: one-cycle tick every DIV clocks (1 us at DIV = f_clk / 1 MHz).
module us_tick_gen #(
  parameter int unsigned DIV = 50
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);
  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    tick_d = 1'b0;
    if (cnt_q == CW'(DIV - 1)) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/dht11_responder.sv
// DHT11 sensor emulator: answers a host start pulse with ACK plus a 40-bit frame.
// Define DHT11_RESPONDER_FAULT_INJECT_EN to add corrupt_checksum (flips checksum LSB).
module dht11_responder
  import dht11_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ    = DEF_CLK_FREQ_HZ,
  parameter int unsigned START_MIN_US   = DEF_START_MIN_US,
  parameter int unsigned REPLY_DELAY_US = DEF_REPLY_DELAY_US,
  parameter int unsigned ACK_US         = DEF_ACK_US,
  parameter int unsigned BIT_LOW_US     = DEF_BIT_LOW_US,
  parameter int unsigned BIT0_HIGH_US   = DEF_BIT0_HIGH_US,
  parameter int unsigned BIT1_HIGH_US   = DEF_BIT1_HIGH_US
) (
  input  logic       clock,
  input  logic       reset,
  inout  wire        transmission_line,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_float,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_float,
`ifdef DHT11_RESPONDER_FAULT_INJECT_EN
  input  logic       corrupt_checksum,
`endif
  output logic       busy,
  output logic       frame_done,
  output logic       collision
);
  localparam logic [15:0] START_MIN = 16'(START_MIN_US);
  localparam logic [15:0] REPLY_DLY = 16'(REPLY_DELAY_US);
  localparam logic [15:0] ACK_DUR   = 16'(ACK_US);
  localparam logic [15:0] BIT_LOW   = 16'(BIT_LOW_US);
  localparam logic [15:0] BIT0_HIGH = 16'(BIT0_HIGH_US);
  localparam logic [15:0] BIT1_HIGH = 16'(BIT1_HIGH_US);

  logic         tick;
  logic         line_meta_q, line_sync_q;
  logic [1:0]   own_hist_q;
  logic [2:0]   state_q, state_d;
  logic [15:0]  phase_q, phase_d;
  logic [39:0]  shreg_q, shreg_d;
  logic [5:0]   idx_q, idx_d;
  logic         busy_q, busy_d, done_q, done_d, col_q, col_d, drive_q, drive_d;
  logic         chk_flip, contend;
  logic [15:0]  high_dur;
  dht11_frame_t snap;

  us_tick_gen #(.DIV(CLK_FREQ_HZ / 1_000_000)) u_tick (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

`ifdef DHT11_RESPONDER_FAULT_INJECT_EN
  assign chk_flip = corrupt_checksum;
`else
  assign chk_flip = 1'b0;
`endif

  always_comb begin
    snap.hum_int    = hum_int;
    snap.hum_float  = hum_float;
    snap.temp_int   = temp_int;
    snap.temp_float = temp_float;
    snap.checksum   = dht11_checksum(hum_int, hum_float, temp_int, temp_float) ^ {7'd0, chk_flip};
  end

  assign contend  = !line_sync_q && (phase_q >= 16'd2);
  assign high_dur = shreg_q[39] ? BIT1_HIGH : BIT0_HIGH;

  always_comb begin
    state_d = state_q;
    phase_d = tick ? phase_q + 16'd1 : phase_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    col_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        phase_d = '0;
        // own_hist_q[1] masks the echo of our own trailing low still in the synchronizer
        if (!line_sync_q && !own_hist_q[1]) begin
          state_d = S_HOST_LOW;
          phase_d = {15'd0, tick};
        end
      end
      S_HOST_LOW: begin
        if (line_sync_q) begin
          state_d = (phase_q >= START_MIN) ? S_DELAY : S_IDLE;
          busy_d  = (phase_q >= START_MIN);
        end else if (phase_q == 16'hFFFF) begin
          phase_d = phase_q;
        end
      end
      S_DELAY: if (tick && phase_q == REPLY_DLY - 16'd1) begin
        state_d = S_ACK_LOW;
        shreg_d = snap;
      end
      S_ACK_LOW: if (tick && phase_q == ACK_DUR - 16'd1) state_d = S_ACK_HIGH;
      S_ACK_HIGH: begin
        if (contend) begin
          state_d = S_IDLE;
          col_d   = 1'b1;
          busy_d  = 1'b0;
        end else if (tick && phase_q == ACK_DUR - 16'd1) begin
          state_d = S_BIT_LOW;
          idx_d   = 6'd39;
        end
      end
      S_BIT_LOW: if (tick && phase_q == BIT_LOW - 16'd1) state_d = S_BIT_HIGH;
      S_BIT_HIGH: begin
        if (contend) begin
          state_d = S_IDLE;
          col_d   = 1'b1;
          busy_d  = 1'b0;
        end else if (tick && phase_q == high_dur - 16'd1) begin
          shreg_d = {shreg_q[38:0], 1'b0};
          idx_d   = idx_q - 6'd1;
          state_d = (idx_q == 6'd0) ? S_END_LOW : S_BIT_LOW;
        end
      end
      default: if (tick && phase_q == BIT_LOW - 16'd1) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
    if (state_d != state_q && state_q != S_IDLE) phase_d = '0;
    drive_d = (state_d == S_ACK_LOW) || (state_d == S_BIT_LOW) || (state_d == S_END_LOW);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      line_meta_q <= 1'b1;
      line_sync_q <= 1'b1;
      own_hist_q  <= '0;
      state_q     <= S_IDLE;
      phase_q     <= '0;
      shreg_q     <= '0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      col_q       <= 1'b0;
      drive_q     <= 1'b0;
    end else begin
      line_meta_q <= transmission_line;
      line_sync_q <= line_meta_q;
      own_hist_q  <= {own_hist_q[0], drive_q};
      state_q     <= state_d;
      phase_q     <= phase_d;
      shreg_q     <= shreg_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      col_q       <= col_d;
      drive_q     <= drive_d;
    end
  end

  assign transmission_line = drive_q ? 1'b0 : 1'bz;
  assign busy              = busy_q;
  assign frame_done        = done_q;
  assign collision         = col_q;

endmodule

// File: doc/dht11_responder.md
Name: dht11_responder

Overview:
- Synthesizable DHT11 sensor emulator: the responder end of the single-wire DHT11 bus.
- Detects a host start pulse and answers with the ACK preamble, then a 40-bit frame (hum_int, hum_float, temp_int, temp_float, checksum).
- Used on the FPGA for hardware-in-the-loop checks of the sensor decoding path without a physical sensor.

Parameters:
- CLK_FREQ_HZ, 50000000, system clock frequency; one microsecond tick every CLK_FREQ_HZ/1000000 clocks.
- START_MIN_US, 18000, minimum host low time accepted as a start request.
- REPLY_DELAY_US, 30, wait after host release before driving ACK.
- ACK_US, 80, duration of the ACK low phase and of the ACK high phase.
- BIT_LOW_US, 50, low phase before each bit and the trailing end low.
- BIT0_HIGH_US, 27, released-high duration for a 0 bit.
- BIT1_HIGH_US, 70, released-high duration for a 1 bit.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high.
- transmission_line  inout  1  open-drain bus: driven 0 or Z, never 1.
- hum_int  input  8  humidity integer byte to report.
- hum_float  input  8  humidity fraction byte.
- temp_int  input  8  temperature integer byte.
- temp_float  input  8  temperature fraction byte.
- busy  output  1  high from start-pulse acceptance to frame end.
- frame_done  output  1  one-cycle pulse after the trailing low is released.
- collision  output  1  one-cycle pulse when a frame is aborted by bus contention.

Behaviour:
- Reset: line released (Z), busy=0, frame_done=0, collision=0, state IDLE, all counters 0.
- Reset mid-frame releases the line on the reset edge.
- Line input passes through a 2-flop synchronizer. All decisions use the synchronized value (2-cycle latency).
- Timing uses a 1 us tick from the prescaler. The phase counter (16 bits) counts ticks and restarts on every state entry.
- IDLE: line released. A synchronized low enters HOST_LOW.
- HOST_LOW: counts low time, saturating at 0xFFFF.
  - Line high with count < START_MIN_US: return to IDLE, no output activity.
  - Line high with count >= START_MIN_US: enter DELAY and set busy=1.
- DELAY: release for REPLY_DELAY_US, then go to ACK_LOW.
- Snapshot: on entry to ACK_LOW, latch the four input bytes and checksum = (hum_int+hum_float+temp_int+temp_float) mod 256 into a 40-bit shift register. Input changes after this point do not affect the frame.
- ACK_LOW: drive 0 for ACK_US, then ACK_HIGH.
- ACK_HIGH: release for ACK_US, then BIT_LOW with bit index 39.
- BIT_LOW: drive 0 for BIT_LOW_US, then BIT_HIGH.
- BIT_HIGH: release for BIT0_HIGH_US or BIT1_HIGH_US per the MSB of the shift register. Then shift left and decrement the index. After bit 0, go to END_LOW.
- END_LOW: drive 0 for BIT_LOW_US, release, pulse frame_done, clear busy, return to IDLE.
- Collision: in ACK_HIGH or BIT_HIGH, a synchronized low seen after the first 2 us of the phase means contention. Release the line, pulse collision, clear busy, go to IDLE.
- Back-to-back starts: a new start pulse while busy is ignored. It can only be detected once the line is released in IDLE.

Optional Feature:
- Macro DHT11_RESPONDER_FAULT_INJECT_EN.
- When defined: extra input port corrupt_checksum (1 bit), sampled at the snapshot. If 1, the transmitted checksum is XORed with 8'h01, giving the decoder an invalid frame.
- When undefined: the port is absent and the checksum is always correct.

Decomposition:
- Shared package dht11_pkg holds:
  - state encoding (IDLE, HOST_LOW, DELAY, ACK_LOW, ACK_HIGH, BIT_LOW, BIT_HIGH, END_LOW);
  - default timing constants;
  - the checksum function, also reused by the decoder-side validity check.
- One natural sub-module, us_tick_gen: parameterized prescaler emitting a one-cycle pulse per microsecond, with synchronous reset.

Test Plan:
- Inputs 35/0/24/0; host drives low 18 ms then releases -> ACK 80 us low/80 us high; bytes 0x23,0x00,0x18,0x00,0x3B; bits of 50 us low plus 27/70 us high; frame_done pulses once; busy=0 afterwards.
- Host low for 10 ms -> no line activity, busy stays 0, state back to IDLE.
- Change temp_int from 24 to 30 during bit 10 -> frame still carries 0x18 and checksum 0x3B.
- Host forces low 20 us into a 1-bit high phase -> line released, collision pulses once, no frame_done.
- Assert reset during the ACK_LOW phase -> line is Z on the next cycle, busy=0; a following 18 ms start produces a full frame.
- With DHT11_RESPONDER_FAULT_INJECT_EN defined and corrupt_checksum=1 on inputs 35/0/24/0 -> transmitted checksum is 0x3A.
